// File: rtl/sc1_port_uart.sv
// rtl/sc1_port_uart.sv - CPU port-mapped UART: toggle-handshake command word, TX FIFO + TX FSM.
// Receiver compiled only when SC1_PORT_UART_RX_EN is defined.
module sc1_port_uart #(
  parameter int CLK_DIV         = 16,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] port_out,
  output logic [31:0] port_in,
  output logic        txd
`ifdef SC1_PORT_UART_RX_EN
  ,
  input  logic        rxd
`endif
);

  localparam int              AW       = FIFO_DEPTH_LOG2;
  localparam int              DEPTH    = 1 << AW;
  localparam logic [AW:0]     CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [15:0]     DIV_M1   = 16'(CLK_DIV - 1);
  localparam logic [15:0]     HALF_M1  = 16'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  logic          tog_d;
  logic          new_cmd, push, rx_pop, clr_sticky, wr_en, tx_pop;
  logic [7:0]    fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  tx_state_t     tx_state_q, tx_state_d;
  logic [15:0]   tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic          txd_q, drop_q, drop_d, full_d, idle_d;
  logic          rxv_d, ovr_d, ferr_d;
  logic [7:0]    rxdata_d;
  logic [31:0]   port_in_q;
  logic          unused_bits;

  // A command is any edge of bit 31 relative to the last sampled value.
  assign new_cmd     = port_out[31] ^ tog_d;
  assign push        = new_cmd & ~port_out[30];
  assign rx_pop      = new_cmd & port_out[30];
  assign clr_sticky  = new_cmd & port_out[29];
  assign wr_en       = push & (count_q != CNT_FULL);
  assign unused_bits = ^port_out[28:8];

  always_comb begin
    count_d = count_q;
    case ({wr_en, tx_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) fifo_q[wr_ptr_q] <= port_out[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (tx_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (count_q != '0) begin
        tx_pop     = 1'b1;
        tx_sh_d    = fifo_q[rd_ptr_q];
        tx_cnt_d   = '0;
        tx_state_d = TX_START;
      end
      TX_START: if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d   = '0;
        tx_bit_d   = '0;
        tx_state_d = TX_DATA;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      TX_DATA: if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        else                  tx_bit_d   = tx_bit_q + 3'd1;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      TX_STOP: if (tx_cnt_q == DIV_M1) begin
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end else tx_cnt_d = tx_cnt_q + 16'd1;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // txd is re-registered from the current state, so the line lags the FSM by one clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      case (tx_state_q)
        TX_START: txd_q <= 1'b0;
        TX_DATA:  txd_q <= tx_sh_q[tx_bit_q];
        default:  txd_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    drop_d = clr_sticky ? 1'b0 : drop_q;
    if (push && count_q == CNT_FULL) drop_d = 1'b1;
  end

  assign full_d = (count_d == CNT_FULL);
  assign idle_d = (count_d == '0) && (tx_state_d == TX_IDLE);

`ifdef SC1_PORT_UART_RX_EN
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        rx_m_q, rx_s_q, rx_p_q, rx_good, rx_bad;
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q;
  logic        rx_valid_q, ovr_q, ferr_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (rx_p_q && !rx_s_q) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_M1) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_DATA: if (rx_cnt_q == DIV_M1) begin
        rx_cnt_d = '0;
        rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        else                  rx_bit_d   = rx_bit_q + 3'd1;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      RX_STOP: if (rx_cnt_q == DIV_M1) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
        rx_good    = rx_s_q;
        rx_bad     = ~rx_s_q;
      end else rx_cnt_d = rx_cnt_q + 16'd1;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rxv_d    = (rx_valid_q & ~rx_pop) | rx_good;
    rxdata_d = rx_good ? rx_sh_q : rx_data_q;
    ovr_d    = clr_sticky ? 1'b0 : ovr_q;
    ferr_d   = clr_sticky ? 1'b0 : ferr_q;
    if (rx_good && rx_valid_q && !rx_pop) ovr_d  = 1'b1;
    if (rx_bad)                           ferr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_p_q     <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_m_q     <= rxd;
      rx_s_q     <= rx_m_q;
      rx_p_q     <= rx_s_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rxdata_d;
      rx_valid_q <= rxv_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end
`else
  assign rxv_d    = 1'b0;
  assign ovr_d    = 1'b0;
  assign ferr_d   = 1'b0;
  assign rxdata_d = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      tog_d     <= 1'b0;
      drop_q    <= 1'b0;
      port_in_q <= '0;
    end else begin
      tog_d     <= port_out[31];
      drop_q    <= drop_d;
      port_in_q <= {port_out[31], full_d, idle_d, rxv_d, ovr_d, drop_d, ferr_d, 17'd0, rxdata_d};
    end
  end

  assign port_in = port_in_q;
  assign txd     = txd_q;

endmodule

// File: tb/tb_sc1_port_uart.sv
// tb/tb_sc1_port_uart.sv - directed vector bench for sc1_port_uart (CLK_DIV=16, 4-entry FIFO).
module tb_sc1_port_uart;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] port_out = 32'h0;
  logic [31:0] port_in;
  logic        txd;
`ifdef SC1_PORT_UART_RX_EN
  logic        rxd = 1'b1;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  sc1_port_uart #(.CLK_DIV(16), .FIFO_DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .port_out (port_out),
    .port_in  (port_in),
    .txd      (txd)
`ifdef SC1_PORT_UART_RX_EN
    ,
    .rxd      (rxd)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] po;
    logic [31:0] exp_pi;
  } vec_t;

  vec_t vt[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    port_out = 32'h0;
    tick();
    tick();
  endtask

  // Bench-side serial decoder for the TX line.
  logic       mon_en = 1'b0;
  logic [7:0] mq[$];
  int         sq[$];
  logic       okq[$];
  int         m_s;
  logic [7:0] m_b;
  logic       m_ok;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en && txd === 1'b0) begin
        m_s = cyc;
        m_ok = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        if (txd !== 1'b0) m_ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(posedge clk);
          #2;
          m_b[i] = txd;
        end
        repeat (16) @(posedge clk);
        #2;
        if (txd !== 1'b1) m_ok = 1'b0;
        mq.push_back(m_b);
        sq.push_back(m_s);
        okq.push_back(m_ok);
      end
    end
  end

`ifdef SC1_PORT_UART_RX_EN
  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (16) tick();
    end
  endtask
`endif

  initial begin
    logic [9:0] bits;
    int k, bad, wait_n;

    vt[0] = '{32'h8000_0001, 32'h8000_0000};
    vt[1] = '{32'h0000_0002, 32'h0000_0000};
    vt[2] = '{32'h8000_0003, 32'h8000_0000};
    vt[3] = '{32'h0000_0004, 32'h0000_0000};
    vt[4] = '{32'h8000_0005, 32'hC000_0000};
    vt[5] = '{32'h0000_0006, 32'h4400_0000};
    vt[6] = '{32'h0000_0006, 32'h4400_0000};
    vt[7] = '{32'hC000_0000, 32'hC400_0000};
    vt[8] = '{32'h6000_0000, 32'h4000_0000};

    // Reset state and single 0x55 frame timing.
    do_reset();
    chk("reset_port_in", port_in, 32'h0);
    chk("reset_txd", {31'd0, txd}, 32'd1);
    reset = 1'b0;
    tick();
    chk("post_reset_idle", port_in, 32'h2000_0000);
    port_out = 32'h8000_0055;
    tick();
    chk("ack_echo", port_in, 32'h8000_0000);
    tick();
    chk("txd_latency_e1", {31'd0, txd}, 32'd1);
    bits = {1'b1, 8'h55, 1'b0};
    for (int t = 2; t <= 161; t++) begin
      tick();
      k = (t - 2) / 16;
      chk($sformatf("txd_bit%0d_t%0d", k, t), {31'd0, txd}, {31'd0, bits[k]});
      if (t == 160) chk("tx_not_idle_in_stop", {31'd0, port_in[29]}, 32'd0);
      if (t == 161) chk("tx_idle_after_stop", {31'd0, port_in[29]}, 32'd1);
    end

    // FIFO fill, overflow drop and frame spacing.
    do_reset();
    reset = 1'b0;
    mq.delete();
    sq.delete();
    okq.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      port_out = vt[i].po;
      tick();
      chk($sformatf("vec%0d", i), port_in, vt[i].exp_pi);
    end
    wait_n = 0;
    while (mq.size() < 5 && wait_n < 1200) begin
      tick();
      wait_n++;
    end
    chk("frame_count", mq.size(), 5);
    for (int i = 0; i < 5 && i < mq.size(); i++) begin
      chk($sformatf("frame%0d_data", i), {24'd0, mq[i]}, 32'(i + 1));
      chk($sformatf("frame%0d_stop", i), {31'd0, okq[i]}, 32'd1);
      if (i > 0) chk($sformatf("frame%0d_spacing", i), sq[i] - sq[i-1], 32'd161);
    end
    repeat (250) tick();
    chk("no_sixth_frame", mq.size(), 5);
    chk("idle_after_burst", port_in, 32'h2000_0000);
    mon_en = 1'b0;

    // Reset in the middle of a frame.
    do_reset();
    reset = 1'b0;
    port_out = 32'h8000_0000;
    repeat (3) tick();
    chk("mid_start_low", {31'd0, txd}, 32'd0);
    repeat (40) tick();
    chk("mid_frame_low", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    port_out = 32'h0;
    tick();
    chk("mid_reset_txd", {31'd0, txd}, 32'd1);
    chk("mid_reset_port_in", port_in, 32'h0);
    tick();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (txd !== 1'b1) bad++;
    end
    chk("no_frame_after_reset", bad, 0);
    chk("idle_after_reset", port_in, 32'h2000_0000);

`ifdef SC1_PORT_UART_RX_EN
    send_rx(8'hA3, 1'b1);
    repeat (4) tick();
    chk("rx_a3_valid", {31'd0, port_in[28]}, 32'd1);
    chk("rx_a3_data", {24'd0, port_in[7:0]}, 32'hA3);
    chk("rx_a3_no_ovr", {31'd0, port_in[27]}, 32'd0);
    send_rx(8'h3C, 1'b1);
    repeat (4) tick();
    chk("rx_3c_ovr", {30'd0, port_in[28:27]}, 32'd3);
    chk("rx_3c_data", {24'd0, port_in[7:0]}, 32'h3C);
    port_out = 32'hE000_0000;
    tick();
    chk("rx_pop_clear", port_in, 32'hA000_003C);
    send_rx(8'h5A, 1'b0);
    rxd = 1'b1;
    repeat (4) tick();
    chk("rx_frame_err", {31'd0, port_in[25]}, 32'd1);
    chk("rx_ferr_valid", {31'd0, port_in[28]}, 32'd0);
    repeat (20) tick();
    rxd = 1'b0;
    repeat (4) tick();
    rxd = 1'b1;
    repeat (200) tick();
    chk("rx_glitch", port_in, 32'hA200_003C);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sc1_port_uart.md
SC1_PORT_UART -- requirements
Module: sc1_port_uart

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clk cycles per serial bit (legal values 4..65535).
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 2, meaning log2 of TX FIFO entries (4 by default).
REQ-003 SHALL have port clk  input  1  clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port port_out  input  32  command word driven by the CPU's port_out.
REQ-006 SHALL have port port_in  output  32  registered status word returned to the CPU's port_in.
REQ-007 SHALL have port txd  output  1  serial transmit line, idle high.
REQ-008 SHALL have port rxd  input  1  serial receive line, asynchronous; present only when SC1_PORT_UART_RX_EN is defined.

Function
REQ-009 SHALL detect a new command when port_out[31] differs from internal toggle register tog_d; tog_d <= port_out[31] every cycle.
REQ-010 SHALL decode a new command as: bit30=0 push port_out[7:0] to TX FIFO; bit30=1 pop RX byte; bit29=1 additionally clears sticky flags.
REQ-011 SHALL drive port_in as: [31] tog_d (ack echo), [30] TX FIFO full, [29] TX idle (FIFO empty and FSM IDLE), [28] rx_valid, [27] rx_overrun, [26] tx_drop, [25] rx_frame_err, [7:0] rx_data, all other bits 0; updated one clock after the cause.
REQ-012 SHALL ignore a push while the FIFO is full and set sticky tx_drop.
REQ-013 SHALL accept a push into an empty FIFO and a TX-FSM pop in the same cycle only in that order across cycles (pop sees entry next cycle); push and pop on a non-empty, non-full FIFO in one cycle SHALL both complete, count unchanged.
REQ-014 SHALL implement TX FSM states IDLE, START, DATA, STOP; IDLE->START pops FIFO when non-empty; START drives 0 for CLK_DIV cycles; DATA drives 8 bits LSB first, CLK_DIV cycles each; STOP drives 1 for CLK_DIV cycles then ->IDLE.
REQ-015 SHALL hold IDLE at least one cycle between frames; back-to-back frame period = 10*CLK_DIV+1 cycles.
REQ-016 SHALL register txd; txd falls on the second rising edge after the edge sampling a push toggle into an empty, idle path.
REQ-017 SHALL wrap FIFO read/write pointers modulo 2^FIFO_DEPTH_LOG2 with an explicit count register (0..2^FIFO_DEPTH_LOG2).

Reset
REQ-018 SHALL on reset set: tog_d=0, port_in=0, txd=1, FSM=IDLE, FIFO count/pointers=0, all sticky flags=0, rx_valid=0, rx_data=0.
REQ-019 SHALL on reset asserted mid-frame return txd to 1 on that same edge and discard the FIFO contents and current frame.

Configuration
REQ-020 SHALL compile the receiver only when macro SC1_PORT_UART_RX_EN is defined.
REQ-021 With SC1_PORT_UART_RX_EN: rxd passes a 2-flop synchronizer; a falling edge starts reception; start bit rechecked at CLK_DIV/2; 8 data bits sampled at bit centres LSB first; stop bit sampled at centre.
REQ-022 With SC1_PORT_UART_RX_EN: start glitch (high at recheck) aborts silently; stop=0 discards byte and sets sticky rx_frame_err; good byte loads rx_data, sets rx_valid; good byte while rx_valid=1 overwrites and sets sticky rx_overrun.
REQ-023 With SC1_PORT_UART_RX_EN: pop clears rx_valid; pop and good byte in same cycle leaves rx_valid=1, new data, no overrun.
REQ-024 Without SC1_PORT_UART_RX_EN: rxd absent, port_in[28:27], [25] and [7:0] read 0, pop commands only update ack.

Verification
REQ-025 Reset, then port_out=0x8000_0055 -> port_in[31]=1 next cycle; txd frame start,0x55 LSB first (1,0,1,0,1,0,1,0),stop; each bit 16 cycles; port_in[29]=1 after stop.
REQ-026 Five pushes 0x01..0x05 on consecutive toggles while idle -> 0x01 transmits, 0x02..0x05 fill FIFO, port_in[30]=1, no drop; sixth push 0x06 before any pop -> port_in[26]=1, 0x06 never sent; frames spaced 161 cycles.
REQ-027 Reset asserted at cycle 40 of a frame -> txd=1 following edge, port_in=0, no further frames.
REQ-028 RX_EN: drive rxd frame 0xA3 at CLK_DIV=16 -> port_in[28]=1, [7:0]=0xA3; second frame 0x3C without pop -> [27]=1, [7:0]=0x3C; pop with bit29 -> [28:27]=0.
REQ-029 RX_EN: frame with stop bit 0 -> port_in[25]=1, rx_valid unchanged; 4-cycle low glitch on rxd -> no byte, no flags.
